// File: rtl/lbp_interp_pipe_if.sv
// Sample-bundle handshake between the corner fetch stage, the LBP interpolator
// and the threshold/code stage.
interface lbp_interp_pipe_if #(
  parameter int DW = 8
);
  logic             done_i;
  logic [DW-1:0]    mid_i;
  logic [4*DW-1:0]  axis_i;
  logic [16*DW-1:0] diag_i;
  logic             ready_o;
  logic [8*DW-1:0]  s_o;
  logic [DW-1:0]    mid_o;
  logic             done_o;

  modport master (
    output done_i, mid_i, axis_i, diag_i,
    input  ready_o, s_o, mid_o, done_o
  );

  modport slave (
    input  done_i, mid_i, axis_i, diag_i,
    output ready_o, s_o, mid_o, done_o
  );
endinterface

// File: rtl/lbp_interp_pipe.sv
// Bilinear interpolator for circular LBP sampling at radius R: axial samples pass
// through, the four diagonal samples are blended from their four corner pixels.
module lbp_interp_pipe #(
  parameter int R      = 2,
  parameter int DW     = 8,
  parameter int WF     = 8,
  parameter int SHARED = 0
) (
  input logic              clk,
  input logic              rst,
  lbp_interp_pipe_if.slave bus
);

  localparam int AW = DW + 2*WF + 2;

  // Fractional part of R/sqrt(2) in units of 2^-WF, rounded, using 1e-8 fixed point.
  function automatic longint calc_f(input int r, input int wf);
    longint fr;
    fr = (longint'(r) * 64'd70710678) % 64'd100000000;
    return (fr * (longint'(1) << wf) + 64'd50000000) / 64'd100000000;
  endfunction

  localparam longint F = calc_f(R, WF);
  localparam longint G = (longint'(1) << WF) - F;
  localparam logic [AW-1:0] W_GG = AW'(G * G);
  localparam logic [AW-1:0] W_FG = AW'(F * G);
  localparam logic [AW-1:0] W_FF = AW'(F * F);
  localparam logic [AW-1:0] RND  = AW'(longint'(1) << (2*WF - 1));

  typedef logic [3:0][AW-1:0] prod_t;

  function automatic prod_t products(input logic [4*DW-1:0] cor);
    prod_t p;
    p[0] = AW'(cor[0    +: DW]) * W_GG;
    p[1] = AW'(cor[DW   +: DW]) * W_FG;
    p[2] = AW'(cor[2*DW +: DW]) * W_FG;
    p[3] = AW'(cor[3*DW +: DW]) * W_FF;
    return p;
  endfunction

  // Weights sum to 2^(2WF), so the rounded quotient always fits in DW bits.
  function automatic logic [DW-1:0] round_sum(input prod_t p);
    logic [AW-1:0] acc;
    acc = p[0] + p[1] + p[2] + p[3] + RND;
    return acc[2*WF +: DW];
  endfunction

  function automatic logic [8*DW-1:0] assemble(input logic [4*DW-1:0] ax,
                                               input logic [3:0][DW-1:0] dg);
    logic [8*DW-1:0] s;
    for (int k = 0; k < 4; k++) begin
      s[2*k*DW +: DW]     = ax[k*DW +: DW];
      s[(2*k+1)*DW +: DW] = dg[k];
    end
    return s;
  endfunction

  logic [8*DW-1:0] s_reg;
  logic [DW-1:0]   mid_reg;
  logic            done_reg;
  logic            ready_reg;

  assign bus.s_o     = s_reg;
  assign bus.mid_o   = mid_reg;
  assign bus.done_o  = done_reg;
  assign bus.ready_o = ready_reg;

  if (SHARED == 0) begin : g_pipe
    logic                in_vld, prod_vld, sum_vld;
    logic [DW-1:0]       in_mid, prod_mid, sum_mid;
    logic [4*DW-1:0]     in_axis, prod_axis, sum_axis;
    logic [16*DW-1:0]    in_diag;
    prod_t               prod [4];
    logic [3:0][DW-1:0]  sum_res;

    assign ready_reg = 1'b1;

    // Capture | products | sum+round | output; data moves every cycle, valids track it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_vld    <= 1'b0;
        prod_vld  <= 1'b0;
        sum_vld   <= 1'b0;
        in_mid    <= '0;
        prod_mid  <= '0;
        sum_mid   <= '0;
        in_axis   <= '0;
        prod_axis <= '0;
        sum_axis  <= '0;
        in_diag   <= '0;
        for (int k = 0; k < 4; k++) prod[k] <= '0;
        sum_res   <= '0;
        s_reg     <= '0;
        mid_reg   <= '0;
        done_reg  <= 1'b0;
      end else begin
        in_vld   <= bus.done_i;
        prod_vld <= in_vld;
        sum_vld  <= prod_vld;
        done_reg <= sum_vld;
        if (bus.done_i) begin
          in_mid  <= bus.mid_i;
          in_axis <= bus.axis_i;
          in_diag <= bus.diag_i;
        end
        if (in_vld) begin
          prod_mid  <= in_mid;
          prod_axis <= in_axis;
          for (int k = 0; k < 4; k++) prod[k] <= products(in_diag[k*4*DW +: 4*DW]);
        end
        if (prod_vld) begin
          sum_mid  <= prod_mid;
          sum_axis <= prod_axis;
          for (int k = 0; k < 4; k++) sum_res[k] <= round_sum(prod[k]);
        end
        if (sum_vld) begin
          s_reg   <= assemble(sum_axis, sum_res);
          mid_reg <= sum_mid;
        end
      end
    end
  end else begin : g_shared
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [1:0]         k;
    logic [DW-1:0]      hold_mid;
    logic [4*DW-1:0]    hold_axis;
    logic [16*DW-1:0]   hold_diag;
    logic               prod_vld;
    logic [1:0]         prod_k;
    prod_t              prod;
    logic [3:0][DW-1:0] res;
    logic               fin;

    // One engine walks the diagonals; fin marks the cycle after the last result lands.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= IDLE;
        k         <= 2'd0;
        hold_mid  <= '0;
        hold_axis <= '0;
        hold_diag <= '0;
        prod_vld  <= 1'b0;
        prod_k    <= 2'd0;
        prod      <= '0;
        res       <= '0;
        fin       <= 1'b0;
        s_reg     <= '0;
        mid_reg   <= '0;
        done_reg  <= 1'b0;
        ready_reg <= 1'b1;
      end else begin
        done_reg <= 1'b0;
        prod_vld <= 1'b0;
        fin      <= prod_vld && (prod_k == 2'd3);
        if (prod_vld) res[prod_k] <= round_sum(prod);
        case (state)
          IDLE: begin
            if (bus.done_i) begin
              hold_mid  <= bus.mid_i;
              hold_axis <= bus.axis_i;
              hold_diag <= bus.diag_i;
              k         <= 2'd0;
              ready_reg <= 1'b0;
              state     <= RUN;
            end
          end
          RUN: begin
            prod     <= products(hold_diag[int'(k)*4*DW +: 4*DW]);
            prod_k   <= k;
            prod_vld <= 1'b1;
            k        <= k + 2'd1;
            if (k == 2'd3) state <= DRAIN;
          end
          DRAIN: begin
            if (fin) begin
              s_reg     <= assemble(hold_axis, res);
              mid_reg   <= hold_mid;
              done_reg  <= 1'b1;
              ready_reg <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lbp_interp_pipe.sv
// Bench for lbp_interp_pipe: every radius 1..8 in both architectures, driven with the
// same bundles and checked by per-instance scoreboards against a bilinear reference model.
module tb_lbp_interp_pipe;

  localparam int DW   = 8;
  localparam int NCFG = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             done;
  logic [DW-1:0]    mid;
  logic [4*DW-1:0]  axis;
  logic [16*DW-1:0] diag;

  logic [8*DW-1:0] s_obs     [NCFG];
  logic [DW-1:0]   mid_obs   [NCFG];
  logic            done_obs  [NCFG];
  logic            ready_obs [NCFG];
  logic            pending   [NCFG];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8*DW-1:0] s;
    logic [DW-1:0]   m;
    int              due;
  } exp_t;

  // Reference: F from real arithmetic, then the exact rounded bilinear blend with WF=8.
  function automatic logic [DW-1:0] model_diag(input int r, input logic [4*DW-1:0] cor);
    real    x;
    longint f, g, acc;
    x   = r * 0.70710678;
    f   = longint'($rtoi((x - $floor(x)) * 256.0 + 0.5));
    g   = 256 - f;
    acc = longint'(cor[0 +: 8]) * g * g + longint'(cor[8 +: 8]) * f * g
        + longint'(cor[16 +: 8]) * g * f + longint'(cor[24 +: 8]) * f * f;
    acc = (acc + 32768) >> 16;
    return acc[7:0];
  endfunction

  function automatic logic [8*DW-1:0] model_s(input int r, input logic [4*DW-1:0] a,
                                              input logic [16*DW-1:0] d);
    logic [8*DW-1:0] s;
    for (int k = 0; k < 4; k++) begin
      s[2*k*DW +: DW]     = a[k*DW +: DW];
      s[(2*k+1)*DW +: DW] = model_diag(r, d[k*4*DW +: 4*DW]);
    end
    return s;
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int RR  = gi % 8 + 1;
    localparam int SH  = gi / 8;
    localparam int LAT = (SH != 0) ? 6 : 3;

    lbp_interp_pipe_if #(.DW(DW)) ifc ();

    lbp_interp_pipe #(.R(RR), .DW(DW), .WF(8), .SHARED(SH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
    );

    assign ifc.done_i    = done;
    assign ifc.mid_i     = mid;
    assign ifc.axis_i    = axis;
    assign ifc.diag_i    = diag;
    assign s_obs[gi]     = ifc.s_o;
    assign mid_obs[gi]   = ifc.mid_o;
    assign done_obs[gi]  = ifc.done_o;
    assign ready_obs[gi] = ifc.ready_o;

    exp_t q [$];
    exp_t e;
    int   acc_cyc = -100;
    logic exp_ready;

    // Scoreboard: push on accept, compare when each result falls due, flag stray pulses.
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        acc_cyc = -100;
      end else begin
        if (q.size() != 0 && cyc == q[0].due) begin
          e = q.pop_front();
          vectors++;
          assert (done_obs[gi] === 1'b1 && s_obs[gi] === e.s && mid_obs[gi] === e.m)
          else begin
            miscompares++;
            $error("[TB] FAIL cfg%0d_result: done=%0b s=%h mid=%h, expected done=1 s=%h mid=%h",
                   gi, done_obs[gi], s_obs[gi], mid_obs[gi], e.s, e.m);
          end
        end else begin
          assert (done_obs[gi] === 1'b0)
          else begin
            miscompares++;
            $error("[TB] FAIL cfg%0d_stray_done: done=%0b, expected 0", gi, done_obs[gi]);
          end
        end
        exp_ready = (SH == 0) || (cyc <= acc_cyc) || (cyc >= acc_cyc + 7);
        assert (ready_obs[gi] === exp_ready)
        else begin
          miscompares++;
          $error("[TB] FAIL cfg%0d_ready: ready=%0b, expected %0b", gi, ready_obs[gi], exp_ready);
        end
        if (done === 1'b1 && ready_obs[gi] === 1'b1) begin
          e.s   = model_s(RR, axis, diag);
          e.m   = mid;
          e.due = cyc + 1 + LAT;
          q.push_back(e);
          acc_cyc = cyc;
        end
      end
      pending[gi] = (q.size() != 0);
    end
  end

  task automatic applyStimulus(input logic v, input logic [DW-1:0] m,
                               input logic [4*DW-1:0] a, input logic [16*DW-1:0] d);
    @(posedge clk);
    #1;
    done = v;
    mid  = m;
    axis = a;
    diag = d;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, mid, axis, diag);
  endtask

  task automatic checkOutput(input int idx, input logic [8*DW-1:0] exp_s,
                             input logic [DW-1:0] exp_mid, input string tag);
    vectors++;
    assert (s_obs[idx] === exp_s && mid_obs[idx] === exp_mid)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: s=%h mid=%h, expected s=%h mid=%h",
             tag, s_obs[idx], mid_obs[idx], exp_s, exp_mid);
    end
  endtask

  task automatic checkReset(input string tag);
    for (int i = 0; i < NCFG; i++) begin
      vectors++;
      assert (s_obs[i] === '0 && mid_obs[i] === '0 && done_obs[i] === 1'b0 && ready_obs[i] === 1'b1)
      else begin
        miscompares++;
        $error("[TB] FAIL %s cfg%0d: s=%h mid=%h done=%0b ready=%0b, expected s=0 mid=0 done=0 ready=1",
               tag, i, s_obs[i], mid_obs[i], done_obs[i], ready_obs[i]);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    done = 1'b0;
    mid  = '0;
    axis = '0;
    diag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("reset_state");
    @(posedge clk);
    #1 rst = 1'b0;

    // Flat patch: every diagonal must reproduce the common corner value.
    applyStimulus(1'b1, 8'h5A, {8'd4, 8'd3, 8'd2, 8'd1}, {16{8'd100}});
    idle(10);
    @(negedge clk);
    checkOutput(1, {8'd100, 8'd4, 8'd100, 8'd3, 8'd100, 8'd2, 8'd100, 8'd1}, 8'h5A, "r2_flat_pipe");
    checkOutput(9, {8'd100, 8'd4, 8'd100, 8'd3, 8'd100, 8'd2, 8'd100, 8'd1}, 8'h5A, "r2_flat_shared");

    // Single-corner impulses per diagonal, plus a saturated patch.
    applyStimulus(1'b1, 8'hC3, {8'd40, 8'd30, 8'd20, 8'd10},
                  {{8'd0, 8'd200, 8'd0, 8'd0}, {4{8'd255}}, {8'd255, 24'd0}, {24'd0, 8'd255}});
    idle(10);
    @(negedge clk);
    checkOutput(1, {8'd49, 8'd40, 8'd255, 8'd30, 8'd44, 8'd20, 8'd88, 8'd10}, 8'hC3, "r2_corners_pipe");
    checkOutput(9, {8'd49, 8'd40, 8'd255, 8'd30, 8'd44, 8'd20, 8'd88, 8'd10}, 8'hC3, "r2_corners_shared");
    idle(5);
    @(negedge clk);
    checkOutput(1, {8'd49, 8'd40, 8'd255, 8'd30, 8'd44, 8'd20, 8'd88, 8'd10}, 8'hC3, "r2_hold_pipe");
    checkOutput(9, {8'd49, 8'd40, 8'd255, 8'd30, 8'd44, 8'd20, 8'd88, 8'd10}, 8'hC3, "r2_hold_shared");

    // Ten back-to-back bundles with distinct centres.
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 8'(i + 16), $urandom(), {$urandom(), $urandom(), $urandom(), $urandom()});
    idle(10);

    // done held high for 20 cycles while the data keeps changing.
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 8'(i + 64), $urandom(), {$urandom(), $urandom(), $urandom(), $urandom()});
    idle(10);

    // Reset two cycles after an accept: the bundle must vanish without a pulse.
    applyStimulus(1'b1, 8'hEE, $urandom(), {$urandom(), $urandom(), $urandom(), $urandom()});
    idle(2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkReset("reset_mid_run");
    @(posedge clk);
    #1 rst = 1'b0;
    idle(8);
    @(negedge clk);
    checkReset("after_reset_quiet");
    applyStimulus(1'b1, 8'h3C, {8'd9, 8'd8, 8'd7, 8'd6}, {16{8'd100}});
    idle(10);
    @(negedge clk);
    checkOutput(1, {8'd100, 8'd9, 8'd100, 8'd8, 8'd100, 8'd7, 8'd100, 8'd6}, 8'h3C, "r2_post_reset_pipe");
    checkOutput(9, {8'd100, 8'd9, 8'd100, 8'd8, 8'd100, 8'd7, 8'd100, 8'd6}, 8'h3C, "r2_post_reset_shared");

    // Random sweep with a sparse, irregular valid pattern.
    for (int i = 0; i < 40; i++)
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom()), $urandom(),
                    {$urandom(), $urandom(), $urandom(), $urandom()});
    idle(12);
    @(negedge clk);
    for (int i = 0; i < NCFG; i++) begin
      vectors++;
      assert (pending[i] === 1'b0)
      else begin
        miscompares++;
        $error("[TB] FAIL cfg%0d_drain: results outstanding=%0b, expected 0", i, pending[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
